// File: rtl/data_c_pkg.sv
// Shared definitions for the data_c latency-absorbing collector: counter sizing,
// status encoding and the supported depth ceiling.
package data_c_pkg;

  localparam int DATA_C_MAX_DEPTH = 256;

  typedef enum logic {
    ST_OK,
    ST_OVERFLOW
  } data_c_status_e;

  function automatic int clog2_plus1(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/data_c_sync_fifo_core.sv
// Result buffer: storage, wrapping pointers, occupancy and the optional zero-latency
// bypass path (enabled by DATA_C_LATENCY_ABSORB_BYPASS_EN).
module data_c_sync_fifo_core
  import data_c_pkg::*;
#(
  parameter  int DSIZE = 8,
  parameter  int DEPTH = 4,
  localparam int CSIZE = clog2_plus1(DEPTH),
  localparam int PSIZE = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [DSIZE-1:0] data_o,
  output logic             full_o
);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [PSIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [PSIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CSIZE-1:0] occ_q, occ_d;
  logic             empty;
  logic             bypass;
  logic             pop_mem;
  logic             wr_en;

  // Explicit compare-and-wrap so non-power-of-2 depths work.
  function automatic logic [PSIZE-1:0] ptr_inc(input logic [PSIZE-1:0] p);
    return (p == PSIZE'(DEPTH - 1)) ? '0 : p + PSIZE'(1);
  endfunction

  assign empty  = (occ_q == '0);
  assign full_o = (occ_q == CSIZE'(DEPTH));

`ifdef DATA_C_LATENCY_ABSORB_BYPASS_EN
  assign bypass = empty && push_i && !rst;
`else
  assign bypass = 1'b0;
`endif

  assign valid_o = !rst && (!empty || bypass);
  assign pop_mem = !rst && !empty && ready_i;
  // A bypassed result that is consumed immediately never touches storage.
  assign wr_en   = push_i && (!full_o || pop_mem) && !(bypass && ready_i);

  always_comb begin
    data_o = '0;
    if (!rst && !empty) begin
      data_o = mem_q[rd_ptr_q];
    end else if (bypass) begin
      data_o = push_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_en   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_mem ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en && !pop_mem) begin
      occ_d = occ_q + CSIZE'(1);
    end else if (!wr_en && pop_mem) begin
      occ_d = occ_q - CSIZE'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/data_c_latency_absorb.sv
// Collector for a fixed-latency, non-stallable pipeline: credit-gated issue, buffered
// results, valid/ready output. DATA_C_LATENCY_ABSORB_BYPASS_EN enables empty-FIFO bypass.
module data_c_latency_absorb
  import data_c_pkg::*;
#(
  parameter  int DSIZE = 8,
  parameter  int DEPTH = 4,
  localparam int CSIZE = clog2_plus1(DEPTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  output logic             issue,
  input  logic             rsp_valid,
  input  logic [DSIZE-1:0] rsp_data,
  output logic             down_valid,
  output logic [DSIZE-1:0] down_data,
  input  logic             down_ready,
  output logic [CSIZE-1:0] credits,
  output logic             overflow
);

  logic [CSIZE-1:0] credits_q, credits_d;
  data_c_status_e   status_q, status_d;
  logic             pop;
  logic             fifo_full;

  assign up_ready = (credits_q != '0) && !rst;
  assign issue    = up_valid && up_ready;
  assign pop      = down_valid && down_ready;
  assign credits  = credits_q;
  assign overflow = (status_q == ST_OVERFLOW);

  always_comb begin
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CSIZE'(1);
      // Saturate: stray results after a reset can pop without a matching issue.
      2'b01:   if (credits_q != CSIZE'(DEPTH)) credits_d = credits_q + CSIZE'(1);
      default: credits_d = credits_q;
    endcase
    status_d = status_q;
    if (rsp_valid && fifo_full && !pop) begin
      status_d = ST_OVERFLOW;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      credits_q <= CSIZE'(DEPTH);
      status_q  <= ST_OK;
    end else begin
      credits_q <= credits_d;
      status_q  <= status_d;
    end
  end

  data_c_sync_fifo_core #(
    .DSIZE(DSIZE),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock      (clock),
    .rst        (rst),
    .push_i     (rsp_valid),
    .push_data_i(rsp_data),
    .ready_i    (down_ready),
    .valid_o    (down_valid),
    .data_o     (down_data),
    .full_o     (fifo_full)
  );

endmodule
